// File: rtl/dm_port_scheduler.sv
// Data-memory port sequencer: drains the store buffer ahead of any pipeline load,
// issues loads on the same port, extracts/extends load data and answers fences.
module dm_port_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [73:0] fifo_data_out,
  input  logic        fifo_empty,
  input  logic        st_push,
  output logic        fifo_rd_en,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic        ld_done,
  output logic [31:0] ld_rdata,
  input  logic        fence_req,
  output logic        fence_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        latch_en;
  logic [31:0] ext_data;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        unused_fifo_bits;

  assign unused_fifo_bits = ^fifo_data_out[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stores always win in IDLE; a load is only started with no push in flight
  // and not in the ld_done cycle, where ld_req is still held from the last load.
  always_comb begin
    state_nxt  = state;
    latch_en   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_wstrb  = 4'h0;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_REQ;
        end else if (ld_req && !st_push && !ld_done) begin
          state_nxt = LD_REQ;
          latch_en  = 1'b1;
        end
      end
      ST_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_data_out[73:42];
        mem_wdata = fifo_data_out[41:10];
        mem_wstrb = fifo_data_out[9:6];
        if (mem_gnt) begin
          fifo_rd_en = !fifo_empty;
          state_nxt  = IDLE;
        end
      end
      LD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {lat_addr[31:2], 2'b00};
        if (mem_gnt) state_nxt = LD_WAIT;
      end
      LD_WAIT: begin
        if (mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr     <= 32'h0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
    end else if (latch_en) begin
      lat_addr     <= ld_addr;
      lat_size     <= ld_size;
      lat_unsigned <= ld_unsigned;
    end
  end

  always_comb begin
    byte_lane = 8'h0;
    half_lane = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_addr[1:0])
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    case (lat_size)
      2'b00:   ext_data = lat_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   ext_data = lat_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_done  <= 1'b0;
      ld_rdata <= 32'h0;
    end else begin
      ld_done <= (state == LD_WAIT) && mem_rvalid;
      if ((state == LD_WAIT) && mem_rvalid) ld_rdata <= ext_data;
    end
  end

  assign fence_done = fence_req && (state == IDLE) && fifo_empty && !st_push;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dm_port_scheduler.sv
// Directed bench for dm_port_scheduler with a store-buffer model and a small
// zero-wait data memory that can be held off or made to return stray rvalids.
module tb_dm_port_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [73:0] fifo_data_out;
  logic        fifo_empty;
  logic        st_push = 1'b0;
  logic        fifo_rd_en;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic [1:0]  ld_size = 2'b00;
  logic        ld_unsigned = 1'b0;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic        fence_req = 1'b0;
  logic        fence_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  logic [73:0] sb_mem [8];
  logic [2:0]  sb_wp = 3'd0;
  logic [2:0]  sb_rp = 3'd0;
  logic [31:0] dmem [16];
  logic        rv_en = 1'b1;
  logic        rv_force = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr [3];
  logic [31:0] exp_data [3];
  logic [3:0]  exp_strb [3];

  always #5 clk = ~clk;

  dm_port_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .st_push(st_push),
    .fifo_rd_en(fifo_rd_en),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .ld_done(ld_done), .ld_rdata(ld_rdata),
    .fence_req(fence_req), .fence_done(fence_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  assign fifo_empty    = (sb_wp == sb_rp);
  assign fifo_data_out = sb_mem[sb_rp];

  always @(posedge clk) begin
    if (fifo_rd_en) sb_rp <= sb_rp + 3'd1;
  end

  // Memory: writes land at the granting edge, reads return on the next cycle
  always @(posedge clk) begin
    if (mem_req && mem_gnt && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) dmem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rvalid <= (mem_req && mem_gnt && !mem_we && rv_en) || rv_force;
    mem_rdata  <= dmem[mem_addr[5:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushEntry(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    sb_mem[sb_wp] = {addr, data, strb, 6'h0};
    sb_wp = sb_wp + 3'd1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    ld_addr     = addr;
    ld_size     = size;
    ld_unsigned = uns;
    ld_req      = 1'b1;
  endtask

  task automatic runLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp, input string tag, output int lat);
    lat = -1;
    applyStimulus(addr, size, uns);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ld_done) begin
        lat = n;
        checkOutput(tag, ld_rdata, exp);
        break;
      end
      nextCycle();
    end
    if (lat < 0) checkOutput("ld_timeout", 32'(ld_done), 32'd1);
    nextCycle();
    ld_req = 1'b0;
  endtask

  initial begin
    int lat;
    int pops;
    logic seen;

    exp_addr[0] = 32'h0000_0100; exp_data[0] = 32'h1111_1111; exp_strb[0] = 4'b1111;
    exp_addr[1] = 32'h0000_0108; exp_data[1] = 32'h0000_AB00; exp_strb[1] = 4'b0010;
    exp_addr[2] = 32'h0000_010C; exp_data[2] = 32'hDEAD_BEEF; exp_strb[2] = 4'b1100;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] reset state");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rst_ctl", {22'h0, mem_req, mem_we, fifo_rd_en, ld_done, fence_done, busy, mem_wstrb}, 32'h0);
      checkOutput("rst_bus", mem_addr | mem_wdata | ld_rdata, 32'h0);
      nextCycle();
    end

    $display("[TB] store drain");
    mem_gnt = 1'b1;
    for (int k = 0; k < 3; k++) pushEntry(exp_addr[k], exp_data[k], exp_strb[k]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("drain_we", 32'(mem_we), 32'(i % 2));
      checkOutput("drain_pop", 32'(fifo_rd_en), 32'(i % 2));
      if (i % 2 == 1) begin
        checkOutput("drain_addr", mem_addr, exp_addr[i/2]);
        checkOutput("drain_data", mem_wdata, exp_data[i/2]);
        checkOutput("drain_strb", 32'(mem_wstrb), 32'(exp_strb[i/2]));
      end
      nextCycle();
    end
    checkOutput("drain_empty", 32'(fifo_empty), 32'd1);

    $display("[TB] load ordering");
    pushEntry(32'h0000_0110, 32'h0000_0001, 4'b1111);
    pushEntry(32'h0000_0104, 32'h80F1_7F02, 4'b1111);
    applyStimulus(32'h0000_0104, 2'b10, 1'b0);
    pops = 0;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (fifo_rd_en) pops++;
      if (mem_req && !mem_we && !seen) begin
        seen = 1'b1;
        checkOutput("order_pops", 32'(pops), 32'd2);
        checkOutput("order_addr", mem_addr, 32'h0000_0104);
      end
      if (ld_done) begin
        checkOutput("order_data", ld_rdata, 32'h80F1_7F02);
        break;
      end
      nextCycle();
    end
    checkOutput("order_seen", 32'(seen), 32'd1);
    nextCycle();
    ld_req = 1'b0;

    $display("[TB] extraction");
    runLoad(32'h0000_0107, 2'b00, 1'b0, 32'hFFFF_FF80, "ext_b3_s", lat);
    checkOutput("ld_latency", 32'(lat), 32'd3);
    runLoad(32'h0000_0106, 2'b01, 1'b1, 32'h0000_80F1, "ext_h2_u", lat);
    runLoad(32'h0000_0105, 2'b00, 1'b0, 32'h0000_007F, "ext_b1_s", lat);
    runLoad(32'h0000_0106, 2'b01, 1'b0, 32'hFFFF_80F1, "ext_h2_s", lat);
    runLoad(32'h0000_0107, 2'b01, 1'b1, 32'h0000_80F1, "ext_h3_u", lat);
    runLoad(32'h0000_0104, 2'b11, 1'b0, 32'h80F1_7F02, "ext_w_sz3", lat);
    runLoad(32'h0000_0104, 2'b00, 1'b1, 32'h0000_0002, "ext_b0_u", lat);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("ld_hold", ld_rdata, 32'h0000_0002);
    nextCycle();

    $display("[TB] backpressure");
    mem_gnt = 1'b0;
    pushEntry(32'h0000_0120, 32'h55AA_55AA, 4'b0101);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_req", {30'h0, mem_req, mem_we}, 32'd3);
      checkOutput("bp_pop", 32'(fifo_rd_en), 32'd0);
      checkOutput("bp_addr", mem_addr, 32'h0000_0120);
      checkOutput("bp_data", mem_wdata, 32'h55AA_55AA);
      nextCycle();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    checkOutput("bp_pop_gnt", 32'(fifo_rd_en), 32'd1);
    checkOutput("bp_strb", 32'(mem_wstrb), 32'h5);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_pop_after", 32'(fifo_rd_en), 32'd0);
    checkOutput("bp_empty", 32'(fifo_empty), 32'd1);
    checkOutput("bp_busy", 32'(busy), 32'd0);
    nextCycle();

    $display("[TB] fence");
    fence_req = 1'b1;
    @(negedge clk);
    checkOutput("fence_idle", 32'(fence_done), 32'd1);
    nextCycle();
    pushEntry(32'h0000_0130, 32'h1234_5678, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("fence_drain", 32'(fence_done), 32'(i == 2));
      nextCycle();
    end
    fence_req = 1'b0;

    $display("[TB] reset during load wait");
    rv_en = 1'b0;
    applyStimulus(32'h0000_0104, 2'b10, 1'b0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_inwait", {30'h0, busy, mem_req}, 32'd2);
    rst_n  = 1'b0;
    ld_req = 1'b0;
    #1;
    checkOutput("rst_async", 32'(busy), 32'd0);
    nextCycle();
    rst_n    = 1'b1;
    rv_force = 1'b1;
    nextCycle();
    rv_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_no_done", {30'h0, ld_done, busy}, 32'd0);
      nextCycle();
    end
    checkOutput("rst_rdata", ld_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dm_port_scheduler.md
# dm_port_scheduler

Sequencer and arbiter for the single data-memory port in the MEM stage. Drains the 4-entry, 74-bit store buffer FIFO into data memory and issues pipeline loads to the same port. It enforces drain-before-load ordering, so a load never reads data that is older than a buffered store. It also extracts and extends load data and answers fence requests.

## Interface
- No parameters. Widths are fixed: 32-bit address and data, 74-bit FIFO entry.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fifo_data_out  in  74  store-buffer head, show-ahead. Fields:
  - [73:42] word-aligned address
  - [41:10] lane-positioned write data
  - [9:6] byte strobes
  - [5:0] reserved, ignored
- fifo_empty  in  1  store buffer empty (registered flag).
- st_push  in  1  pipeline is writing the store buffer this cycle.
- fifo_rd_en  out  1  pop the store-buffer head.
- ld_req  in  1  load request. Held high with its operands until ld_done.
- ld_addr  in  32  load byte address.
- ld_size  in  2  00 byte, 01 half, 10 word.
- ld_unsigned  in  1  zero-extend when 1, sign-extend when 0.
- ld_done  out  1  one-cycle pulse; ld_rdata is valid while it is high.
- ld_rdata  out  32  extended load result.
- fence_req  in  1  level request to wait until all buffered stores are drained.
- fence_done  out  1  high while the fence condition holds.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte strobes.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  memory read data.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, ST_REQ, LD_REQ, LD_WAIT.
- IDLE transitions:
  - If !fifo_empty, go to ST_REQ. Stores always win.
  - Else, if ld_req & ~st_push & ~ld_done, go to LD_REQ. Latch ld_addr, ld_size and ld_unsigned into internal registers.
  - Else, stay in IDLE.
- ST_REQ:
  - Outputs: mem_req=1, mem_we=1. mem_addr, mem_wdata and mem_wstrb are driven combinationally from the fifo_data_out fields.
  - On mem_gnt: fifo_rd_en=1 for exactly that cycle (combinational), then go to IDLE.
  - Without mem_gnt: hold the state and outputs.
- LD_REQ:
  - Outputs: mem_req=1, mem_we=0, mem_addr={latched_addr[31:2],2'b00}, mem_wstrb=0, mem_wdata=0.
  - On mem_gnt, go to LD_WAIT.
- LD_WAIT:
  - mem_req=0.
  - On mem_rvalid: register the extracted result into ld_rdata, set ld_done=1 for the next cycle, and go to IDLE.
- Load extraction, with offset = latched_addr[1:0]:
  - Byte: lane = rdata[8*offset +: 8].
  - Half: lane = rdata[16*offset[1] +: 16]; offset[0] is ignored.
  - Word: the full word.
  - Extension: zero- or sign-extend to 32 bits per the latched ld_unsigned. ld_size 11 is treated as word.
- Ordering: a load is issued only when the store buffer is empty and no push is in flight (st_push=0). A load therefore waits for every earlier store.
- fence_done = fence_req & (state==IDLE) & fifo_empty & ~st_push, combinational.
- ld_rdata holds its value until the next load completes.

## Timing
- Reset values:
  - state IDLE
  - ld_done 0
  - ld_rdata 0
  - all mem_* outputs 0
  - fifo_rd_en 0
  - fence_done 0
  - busy 0
- Reset asserted mid-transaction returns to IDLE immediately. An outstanding memory read is abandoned, and a mem_rvalid arriving after reset is ignored.
- Store drain takes a minimum of 2 cycles per entry (ST_REQ with gnt, then IDLE). A full buffer drains in 8 cycles with mem_gnt tied high.
- Load latency with zero-wait memory:
  - cycle 0: ld_req seen in IDLE
  - cycle 1: LD_REQ, granted
  - cycle 2: LD_WAIT, mem_rvalid
  - cycle 3: ld_done
- mem_gnt and mem_rvalid outside the states that expect them are ignored.
- Simultaneous st_push and ld_req in IDLE with an empty buffer: the load is deferred. At the next cycle fifo_empty=0, so the store is drained first.
- A load arriving while in ST_REQ waits. Loads can starve only while stores keep arriving, which the single-issue pipeline cannot sustain.
- fifo_rd_en is never asserted when fifo_empty=1 or outside ST_REQ.

## Test plan
- **Reset:** release rst_n with an empty buffer and ld_req=0 -> all outputs 0 and busy=0 for 5 cycles.
- **Store drain:** 3 entries queued with mem_gnt=1 -> 3 writes on cycles 1, 3 and 5 with matching addresses, data and strobes. fifo_rd_en pulses on those same cycles.
- **Load ordering:** ld_req to 0x104 issued while 2 stores are pending -> mem_we=0 is seen only after the second fifo_rd_en. The load returns the freshly written word.
- **Extraction:** mem_rdata=0x80F1_7F02 ->
  - byte at offset 3, signed: 0xFFFF_FF80
  - half at offset 2, unsigned: 0x0000_80F1
  - byte at offset 1, signed: 0x0000_007F
- **Backpressure:** mem_gnt held low for 4 cycles in ST_REQ -> outputs stable, fifo_rd_en=0 throughout, a single pop when the grant arrives.
- **Fence and reset:** fence_req with 1 store pending -> fence_done=0 until the drain completes, then 1. Separately, assert rst_n low during LD_WAIT -> no ld_done pulse afterwards.
